nms_peak_detector: RTL

Datapath stage directly downstream of the NMS sequencing controller in the FAST9 accelerator. Captures the eight neighbour scores and the centre score as the controller steps `regAddr`. On `readen`, decides whether the centre pixel is a strict local maximum. Surviving corners (address plus score) are queued in a small output FIFO for the result writer.

---
 rtl/nms_pkg.sv | 23 ++
 rtl/nms_result_fifo.sv | 70 +++++++
 rtl/nms_peak_detector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nms_pkg.sv
// Shared types and constants for the FAST9 NMS peak-detect stage.
// Holds register-file indices, default widths, FSM state enum and result record.
// Imported by nms_peak_detector and nms_result_fifo.
package nms_pkg;

  localparam int         NEIGH_N     = 8;
  localparam logic [3:0] CENTER_IDX  = 4'd8;

  localparam int         SCORE_W_DEF = 8;
  localparam int         ADDR_W_DEF  = 15;

  typedef enum logic {
    COLLECT = 1'b0,
    EVAL    = 1'b1
  } nms_state_t;

  // Result record at the default widths, as seen by the result writer.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  addr;
    logic [SCORE_W_DEF-1:0] score;
  } nms_result_t;

endpackage

// File: rtl/nms_result_fifo.sv
// Purpose: small synchronous FIFO holding surviving corners for the result writer.
// Latency: a push is visible at the head on the next cycle; no combinational bypass.
// Backpressure: pop on pop_rdy && !empty; push into a full FIFO is dropped (drop pulses)
//   unless a pop happens in the same cycle, in which case it is accepted.
// Ports: clock/reset (sync, active-high); push_vld/push_dat; pop_rdy; pop_dat (zero
//   when empty); full, empty, drop status.
module nms_result_fifo
  import nms_pkg::*;
#(
  parameter int W     = ADDR_W_DEF + SCORE_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         pop;
  logic         push_acc;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = pop_rdy && !empty;
  assign push_acc = push_vld && (!full || pop);
  assign drop     = push_vld && full && !pop;
  assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nms_peak_detector.sv
// Purpose: capture 8 neighbour + centre FAST scores, decide strict local maximum, queue corners.
// Latency: readen edge = cycle 0, EVAL in cycle 1, cornerValid rises in cycle 2 (empty FIFO).
// Backpressure: cornerValid/cornerReady pop; a corner arriving at a full FIFO without a pop is
//   dropped and sets sticky overflow.
// Ports: clock, reset (sync, active-high); regWe/regAddr/scoreIn score writes; readen/refAddr
//   evaluation start; cornerValid/cornerReady/cornerAddr/cornerScore result stream; busy,
//   overflow, protoErr status.
// Build option: define NMS_TIEBREAK_EN for the asymmetric tie-break (>= on neighbours 0-3).
module nms_peak_detector
  import nms_pkg::*;
#(
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               regWe,
  input  logic [3:0]         regAddr,
  input  logic [SCORE_W-1:0] scoreIn,
  input  logic               readen,
  input  logic [ADDR_W-1:0]  refAddr,
  output logic               cornerValid,
  input  logic               cornerReady,
  output logic [ADDR_W-1:0]  cornerAddr,
  output logic [SCORE_W-1:0] cornerScore,
  output logic               busy,
  output logic               overflow,
  output logic               protoErr
);

  localparam int RES_W = ADDR_W + SCORE_W;

  // Score register file: entries 0-7 neighbours, 8 centre. Deliberately not reset.
  logic [SCORE_W-1:0] score_q [NEIGH_N+1];
  logic [SCORE_W-1:0] score_d [NEIGH_N+1];

  nms_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  ctr_addr_q, ctr_addr_d;
  logic               overflow_q, overflow_d;
  logic               proto_err_q, proto_err_d;

  logic               is_corner;
  logic               push_vld;
  logic [RES_W-1:0]   push_dat;
  logic [RES_W-1:0]   head_dat;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;
  logic               unused_fifo_full;

  // Writes are accepted in every state, so a centre write in the readen cycle
  // lands at the same edge that enters EVAL and is what EVAL compares against.
  always_comb begin
    score_d = score_q;
    if (regWe && (regAddr <= CENTER_IDX)) begin
      score_d[regAddr] = scoreIn;
    end
  end

  always_ff @(posedge clock) begin
    score_q <= score_d;
  end

  always_comb begin
    is_corner = (score_q[CENTER_IDX] != '0);
    for (int i = 0; i < NEIGH_N; i++) begin
`ifdef NMS_TIEBREAK_EN
      // Lower half wins ties so an equal-score plateau keeps exactly one corner.
      if (i < NEIGH_N / 2) begin
        if (score_q[CENTER_IDX] < score_q[i]) is_corner = 1'b0;
      end else begin
        if (score_q[CENTER_IDX] <= score_q[i]) is_corner = 1'b0;
      end
`else
      if (score_q[CENTER_IDX] <= score_q[i]) is_corner = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_addr_d  = ctr_addr_q;
    proto_err_d = proto_err_q;
    overflow_d  = overflow_q | fifo_drop;
    push_vld    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (readen) begin
          state_d    = EVAL;
          ctr_addr_d = refAddr;
        end
      end
      EVAL: begin
        state_d  = COLLECT;
        push_vld = is_corner;
        // A second readen before the decision completes is a controller bug.
        if (readen) proto_err_d = 1'b1;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= COLLECT;
      ctr_addr_q  <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_addr_q  <= ctr_addr_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign push_dat = {ctr_addr_q, score_q[CENTER_IDX]};

  // The FIFO is reset in the same edge as the FSM, so a decision pending in EVAL
  // when reset is asserted never lands in the queue.
  nms_result_fifo #(
    .W     (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (cornerReady),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign unused_fifo_full = fifo_full;

  assign cornerValid = !fifo_empty;
  assign cornerAddr  = head_dat[RES_W-1:SCORE_W];
  assign cornerScore = head_dat[SCORE_W-1:0];
  assign busy        = (state_q == EVAL);
  assign overflow    = overflow_q;
  assign protoErr    = proto_err_q;

endmodule
